inst_line_responder: RTL and testbench
======================================

// Module: inst_line_responder
// PURPOSE
//  Memory-side responder for instruction-cache line refills. Sits behind the L1 instruction
//  cache, opposite the fetch stage. Accepts one line-read request at a time and returns one
//  LINE_W-bit line after a fixed access latency, using a valid/ready handshake on both channels.
//  A separate line-write port preloads program images.
// PARAMETERS
//  ADDR_W     32   byte-address width of req_addr, wr_addr and rsp_addr
//  LINE_W     128  line width in bits (4 x 32-bit instructions); fixed at 128 here
//  IDX_W      8    line-index width; storage depth is 2**IDX_W lines
//  LATENCY    4    cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  Clk        in   1       rising-edge clock
//  Rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       cache presents a refill request
//  req_ready  out  1       responder can accept a request (high only in IDLE)
//  req_addr   in   ADDR_W  byte address of the missing line; bits [3:0] ignored
//  rsp_valid  out  1       returned line is valid
//  rsp_ready  in   1       cache consumes the line
//  rsp_data   out  LINE_W  line data; word 0 (address +0) in bits [31:0]
//  rsp_addr   out  ADDR_W  line-aligned address of the returned line (bits [3:0] = 0)
//  rsp_err    out  1       address is beyond storage; rsp_data is all zero
//  wr_en      in   1       preload write strobe
//  wr_addr    in   ADDR_W  byte address of the line to write; bits [3:0] ignored
//  wr_data    in   LINE_W  line data to write
// BEHAVIOUR
//  Reset (async, Rst_n=0)
//   - FSM goes to IDLE; latency counter is 0.
//   - req_ready=1 once Rst_n deasserts; rsp_valid=0; rsp_data=0; rsp_addr=0; rsp_err=0.
//   - Storage contents are not reset.
//   - Reset asserted mid-request drops the request; no response is issued afterwards.
//  Indexing
//   - idx = addr[IDX_W+3:4].
//   - Out of range when any bit of addr[ADDR_W-1:IDX_W+4] is nonzero.
//  FSM states and transitions
//   - IDLE: req_ready=1.
//       On req_valid & req_ready: read the indexed line into the response buffer, latch the
//       line-aligned address and the error flag, load counter = LATENCY-1, go to WAIT.
//       If the read is out of range: buffer=0, err=1.
//   - WAIT: req_ready=0.
//       Counter decrements each cycle; when the counter is 0, go to RESP.
//       With LATENCY=1, WAIT lasts exactly one cycle.
//   - RESP: rsp_valid=1; rsp_data, rsp_addr and rsp_err stay stable until handshake.
//       On rsp_valid & rsp_ready: go to IDLE; rsp_valid=0 the next cycle.
//   - Handshake timing: a request accepted at edge T gives rsp_valid=1 after edge T+LATENCY.
//     With rsp_ready held high, rsp_valid is high for exactly one cycle.
//  Backpressure and capacity
//   - rsp_ready=0 holds RESP indefinitely; outputs do not change.
//   - Only one outstanding request exists; req_valid in WAIT or RESP is not accepted.
//   - The next accept can occur at the earliest one cycle after the response handshake.
//  Writes
//   - wr_en writes wr_data to the indexed line at the clock edge in any state.
//   - Out-of-range writes are dropped.
//   - Data is captured at accept time: a write in the same cycle as the accept, or later,
//     does not alter the pending response (read-before-write).
//   - A write at an earlier edge is visible to the request.
// TESTING
//  1 Reset: drive Rst_n=0 mid-WAIT, then release.
//     -> rsp_valid=0, rsp_data=0, req_ready=1; no stray response within 20 cycles.
//  2 Basic read: preload line idx 3 = 128'h0000000C_00000008_00000004_00000000; request 0x34.
//     -> rsp_valid rises exactly 4 cycles after accept; rsp_addr=0x30; rsp_err=0;
//        data matches the preload.
//  3 Backpressure: hold rsp_ready=0 for 10 cycles in RESP; req_valid=1 throughout.
//     -> outputs stable, req_ready=0; one handshake when rsp_ready=1, then re-accept one cycle later.
//  4 Out of range: request 0x0000_1000 with IDX_W=8.
//     -> rsp_err=1, rsp_data=0, rsp_addr=0x1000.
//  5 Write race: write idx 5 = 128'hAAAA.. in the same cycle the request for 0x50 is accepted.
//     -> response carries the old line; a re-request returns 128'hAAAA...
//  6 LATENCY=1 build, back-to-back requests with rsp_ready=1.
//     -> responses one cycle after each accept; one accept every 3 cycles; addresses in order.

Source files
------------

// File: rtl/inst_line_responder.sv
// Instruction-cache line refill responder: one line read at a time from a preloadable line store.
// Latency: rsp_valid rises LATENCY cycles after the request accept edge.
// Backpressure: a stalled rsp_ready holds RESP with stable outputs; no new request is taken until the response handshake.
module inst_line_responder #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int IDX_W   = 8,
   parameter int LATENCY = 4
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [LINE_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LINE_W-1:0] wr_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   localparam int         DEPTH   = 1 << IDX_W;
   // WAIT holds for LATENCY cycles; the counter reaching zero triggers the move to RESP
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [LINE_W-1:0] lineMem [DEPTH];

   stateT            state;
   stateT            nextState;
   logic [3:0]       cnt;
   logic [IDX_W-1:0] reqIdx;
   logic [IDX_W-1:0] wrIdx;
   logic             reqOor;
   logic             wrOor;
   logic             accept;
   logic             unusedBits;

   // Line index comes from the bits just above the byte offset; anything above the index is out of range
   assign reqIdx = req_addr[IDX_W+3:4];
   assign wrIdx  = wr_addr[IDX_W+3:4];
   assign reqOor = |(req_addr >> (IDX_W + 4));
   assign wrOor  = |(wr_addr >> (IDX_W + 4));
   assign accept = req_valid && req_ready;

   // Byte-offset bits are ignored on both address ports
   assign unusedBits = ^{req_addr[3:0], wr_addr[3:0]};

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic and handshake outputs
   always_comb begin
      nextState = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) nextState = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) nextState = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Access latency counter: loaded on accept, counts down while waiting
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt <= 4'd0;
      end else if (accept) begin
         cnt <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Response buffer captured at accept, so later writes never disturb a pending line
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rsp_data <= '0;
         rsp_addr <= '0;
         rsp_err  <= 1'b0;
      end else if (accept) begin
         rsp_addr <= {req_addr[ADDR_W-1:4], 4'b0000};
         rsp_err  <= reqOor;
         rsp_data <= reqOor ? '0 : lineMem[reqIdx];
      end
   end

   // Preload write port; storage is deliberately left out of reset
   always_ff @(posedge Clk) begin
      if (wr_en && !wrOor) lineMem[wrIdx] <= wr_data;
   end

endmodule

// File: tb/tb_inst_line_responder.sv
module tb_inst_line_responder;

   logic         Clk = 1'b0;
   logic         Rst_n;

   // Instance under main test (LATENCY = 4)
   logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
   logic [31:0]  req_addr, rsp_addr, wr_addr;
   logic [127:0] rsp_data, wr_data;

   // Second instance built with LATENCY = 1
   logic         req1Valid, req1Ready, rsp1Valid, rsp1Ready, rsp1Err, wr1En;
   logic [31:0]  req1Addr, rsp1Addr, wr1Addr;
   logic [127:0] rsp1Data, wr1Data;

   inst_line_responder #(.ADDR_W(32), .LINE_W(128), .IDX_W(8), .LATENCY(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   inst_line_responder #(.ADDR_W(32), .LINE_W(128), .IDX_W(8), .LATENCY(1)) dutL1 (
      .Clk(Clk), .Rst_n(Rst_n),
      .req_valid(req1Valid), .req_ready(req1Ready), .req_addr(req1Addr),
      .rsp_valid(rsp1Valid), .rsp_ready(rsp1Ready), .rsp_data(rsp1Data),
      .rsp_addr(rsp1Addr), .rsp_err(rsp1Err),
      .wr_en(wr1En), .wr_addr(wr1Addr), .wr_data(wr1Data)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         err;
      int           acceptCyc;
   } expT;

   expT          sb[$];
   logic [127:0] modelMem [256];
   int           cyc = 0;
   int           nChecks = 0;
   int           nFail = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic expT expectFor(input logic [31:0] addr, input int acc);
      expT e;
      e.addr      = {addr[31:4], 4'b0000};
      e.err       = |addr[31:12];
      e.data      = e.err ? 128'd0 : modelMem[addr[11:4]];
      e.acceptCyc = acc;
      return e;
   endfunction

   // Response monitor for the LATENCY=4 instance: latency, stability and scoreboard data
   logic         prevVld = 1'b0;
   logic         prevHs = 1'b0;
   logic [127:0] prevData;
   logic [31:0]  prevAddr;
   logic         prevErr;
   always @(negedge Clk) begin
      if (!Rst_n) begin
         prevVld = 1'b0;
         prevHs  = 1'b0;
      end else begin
         if (rsp_valid && !prevVld) begin
            if (sb.size() == 0) checkEq("strayRsp", 1'b1, 1'b0);
            else checkEq("latency", 128'(cyc - sb[0].acceptCyc), 128'd4);
         end
         if (rsp_valid && prevVld && !prevHs) begin
            checkEq("stableData", rsp_data, prevData);
            checkEq("stableAddr", 128'(rsp_addr), 128'(prevAddr));
            checkEq("stableErr", 128'(rsp_err), 128'(prevErr));
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checkEq("rspNoExp", 1'b1, 1'b0);
            end else begin
               checkEq("rspAddr", 128'(rsp_addr), 128'(sb[0].addr));
               checkEq("rspErr", 128'(rsp_err), 128'(sb[0].err));
               checkEq("rspData", rsp_data, sb[0].data);
               void'(sb.pop_front());
            end
         end
         prevVld  = rsp_valid;
         prevHs   = rsp_valid && rsp_ready;
         prevData = rsp_data;
         prevAddr = rsp_addr;
         prevErr  = rsp_err;
      end
   end

   task automatic wrLine(input logic [31:0] addr, input logic [127:0] data);
      @(posedge Clk); #1;
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      @(posedge Clk); #1;
      wr_en = 1'b0;
      if (addr[31:12] == 20'd0) modelMem[addr[11:4]] = data;
   endtask

   // Issue one request, wait for accept, push its expectation
   task automatic reqOne(input logic [31:0] addr);
      bit ok = 1'b0;
      @(posedge Clk); #1;
      req_valid = 1'b1; req_addr = addr;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge Clk);
         if (req_ready) begin
            sb.push_back(expectFor(addr, cyc + 1));
            ok = 1'b1;
         end else begin
            @(posedge Clk); #1;
         end
      end
      if (!ok) checkEq("acceptTimeout", 1'b0, 1'b1);
      @(posedge Clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      bit done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge Clk);
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         checkEq("rspTimeout", 1'b0, 1'b1);
         sb.delete();
      end
   endtask

   initial begin
      int acc[4];
      int k, r;
      bit acceptNow;
      bit got;
      logic [127:0] aaaa;
      aaaa = {8{16'hAAAA}};

      Rst_n = 1'b0;
      req_valid = 0; req_addr = '0; rsp_ready = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0;
      req1Valid = 0; req1Addr = '0; rsp1Ready = 1'b1; wr1En = 0; wr1Addr = '0; wr1Data = '0;

      // Reset state
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      checkEq("rstRspValid", 128'(rsp_valid), 128'd0);
      checkEq("rstRspData", rsp_data, 128'd0);
      checkEq("rstRspAddr", 128'(rsp_addr), 128'd0);
      checkEq("rstRspErr", 128'(rsp_err), 128'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      @(negedge Clk);
      checkEq("rstReqReady", 128'(req_ready), 128'd1);

      // Preload every line with a distinct pattern
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = 32'h1000_0000 + 32'(i);
         wrLine(32'(i) << 4, {w ^ 32'h3, w ^ 32'h2, w ^ 32'h1, w});
      end

      // Basic read
      wrLine(32'h30, 128'h0000000C_00000008_00000004_00000000);
      reqOne(32'h34);
      waitDrain();
      reqOne(32'h7F8);
      waitDrain();

      // Out-of-range read
      reqOne(32'h0000_1000);
      waitDrain();

      // Backpressure: rsp_ready low for 10 cycles in RESP, req_valid held
      @(posedge Clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h20;
      @(negedge Clk);
      checkEq("bpAccept", 128'(req_ready), 128'd1);
      sb.push_back(expectFor(32'h20, cyc + 1));
      @(posedge Clk); #1;
      req_addr = 32'h40;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge Clk);
         if (rsp_valid) got = 1'b1;
      end
      if (!got) checkEq("bpRspTimeout", 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkEq("bpReqReady", 128'(req_ready), 128'd0);
         checkEq("bpRspValid", 128'(rsp_valid), 128'd1);
         @(negedge Clk);
      end
      @(posedge Clk); #1;
      rsp_ready = 1'b1;
      @(negedge Clk);
      checkEq("bpHsReqReady", 128'(req_ready), 128'd0);
      @(negedge Clk);
      checkEq("bpAfterHsVld", 128'(rsp_valid), 128'd0);
      checkEq("bpReaccept", 128'(req_ready), 128'd1);
      if (req_ready) sb.push_back(expectFor(32'h40, cyc + 1));
      @(posedge Clk); #1;
      req_valid = 1'b0;
      waitDrain();

      // Write in the same cycle as accept: response keeps the old line
      @(posedge Clk); #1;
      req_valid = 1'b1; req_addr = 32'h50;
      wr_en = 1'b1; wr_addr = 32'h50; wr_data = aaaa;
      @(negedge Clk);
      checkEq("raceAccept", 128'(req_ready), 128'd1);
      sb.push_back(expectFor(32'h50, cyc + 1));
      @(posedge Clk); #1;
      req_valid = 1'b0; wr_en = 1'b0;
      modelMem[5] = aaaa;
      waitDrain();
      reqOne(32'h50);
      waitDrain();

      // Out-of-range write is dropped; line 0 keeps its contents
      wrLine(32'h0001_0000, {4{32'hDEAD_BEEF}});
      reqOne(32'h0);
      waitDrain();

      // Reset in the middle of WAIT drops the request
      reqOne(32'h30);
      @(posedge Clk); #1;
      Rst_n = 1'b0;
      sb.delete();
      @(negedge Clk);
      checkEq("midRstVld", 128'(rsp_valid), 128'd0);
      checkEq("midRstData", rsp_data, 128'd0);
      checkEq("midRstReady", 128'(req_ready), 128'd1);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         checkEq("noStrayRsp", 128'(rsp_valid), 128'd0);
      end
      checkEq("postRstReady", 128'(req_ready), 128'd1);

      // LATENCY=1 instance: back-to-back requests, rsp_ready high
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk); #1;
         wr1En = 1'b1; wr1Addr = 32'(i) << 4; wr1Data = {4{32'hB000_0000 + 32'(i)}};
      end
      @(posedge Clk); #1;
      wr1En = 1'b0;
      req1Valid = 1'b1; req1Addr = 32'h0;
      k = 0; r = 0;
      for (int c = 0; c < 60 && r < 4; c++) begin
         @(negedge Clk);
         if (rsp1Valid) begin
            checkEq("l1Addr", 128'(rsp1Addr), 128'(32'(r) << 4));
            checkEq("l1Data", rsp1Data, {4{32'hB000_0000 + 32'(r)}});
            checkEq("l1Err", 128'(rsp1Err), 128'd0);
            checkEq("l1Latency", 128'(cyc - acc[r]), 128'd1);
            r++;
         end
         acceptNow = req1Valid && req1Ready;
         if (acceptNow && k < 4) begin
            acc[k] = cyc + 1;
            if (k > 0) checkEq("l1Spacing", 128'(acc[k] - acc[k-1]), 128'd3);
            k++;
         end
         @(posedge Clk); #1;
         if (acceptNow) begin
            if (k < 4) req1Addr = 32'(k) << 4;
            else req1Valid = 1'b0;
         end
      end
      if (r < 4) checkEq("l1RspCount", 128'(r), 128'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
